// File: rtl/ktop_join_pkg.sv
// Shared types and helpers for the four-input stream join/reduction stage.
package ktop_join_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } join_state_t;

    localparam int LP_NUM_INPUTS = 4;

    function automatic int num_lanes(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    // Ceiling division; written as quotient + remainder test so a size near
    // the top of the range cannot overflow.
    function automatic logic [63:0] bytes_to_beats(input logic [63:0] bytes,
                                                   input logic [63:0] beat_bytes);
        return (bytes / beat_bytes) + (((bytes % beat_bytes) != 64'd0) ? 64'd1 : 64'd0);
    endfunction

endpackage

// File: rtl/ktop_lane_add2_stage.sv
// One registered pipeline stage: lane-wise two-operand wrapping add with
// valid and enable.
module ktop_lane_add2_stage
    import ktop_join_pkg::*;
#(
    parameter int C_DATA_WIDTH = 512,
    parameter int C_LANE_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic [C_DATA_WIDTH-1:0] a,
    input  logic [C_DATA_WIDTH-1:0] b,
    output logic                    out_valid,
    output logic [C_DATA_WIDTH-1:0] sum
);

    localparam int NUM_LANES = num_lanes(C_DATA_WIDTH, C_LANE_WIDTH);

    logic [NUM_LANES-1:0][C_LANE_WIDTH-1:0] a_l, b_l, s_l;

    assign a_l = a;
    assign b_l = b;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign s_l[l] = a_l[l] + b_l[l];
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            if (in_valid) sum <= s_l;
        end
    end

endmodule

// File: rtl/ktop_stream_join4.sv
// Four-input lockstep stream join with a two-stage lane-wise adder tree,
// regenerated tlast and a one-shot completion pulse.
module ktop_stream_join4
    import ktop_join_pkg::*;
#(
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_LANE_WIDTH      = 32,
    parameter int C_XFER_SIZE_WIDTH = 32
) (
    input  logic                                    aclk,
    input  logic                                    areset,
    input  logic                                    ctrl_start,
    input  logic [C_XFER_SIZE_WIDTH-1:0]            ctrl_xfer_size_in_bytes,
    output logic                                    ctrl_done,
    output logic                                    ctrl_err,
    input  logic [LP_NUM_INPUTS-1:0]                s_axis_tvalid,
    output logic [LP_NUM_INPUTS-1:0]                s_axis_tready,
    input  logic [LP_NUM_INPUTS*C_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [LP_NUM_INPUTS-1:0]                s_axis_tlast,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready,
    output logic [C_DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic                                    m_axis_tlast
);

    localparam int                           NUM_PAIRS = LP_NUM_INPUTS / 2;
    localparam logic [C_XFER_SIZE_WIDTH-1:0] ONE       = C_XFER_SIZE_WIDTH'(1);

    join_state_t                                 state;
    logic [C_XFER_SIZE_WIDTH-1:0]                beats, in_rem, out_rem;
    logic [LP_NUM_INPUTS-1:0][C_DATA_WIDTH-1:0]  din;
    logic [NUM_PAIRS-1:0][C_DATA_WIDTH-1:0]      psum;
    logic [NUM_PAIRS-1:0]                        s1_pair_vld;
    logic                                        s1_valid, s1_last;
    logic                                        s1_en, s2_en, fire, out_hs;

    assign din   = s_axis_tdata;
    assign beats = C_XFER_SIZE_WIDTH'(bytes_to_beats(64'(ctrl_xfer_size_in_bytes),
                                                     64'(C_DATA_WIDTH / 8)));

    assign s2_en  = !m_axis_tvalid || m_axis_tready;
    assign s1_en  = !s1_valid || s2_en;
    // All four inputs move together or not at all; ready follows valid.
    assign fire   = (state == RUN) && (&s_axis_tvalid) && (in_rem != '0) && s1_en;
    assign out_hs = m_axis_tvalid && m_axis_tready;

    assign s_axis_tready = {LP_NUM_INPUTS{fire}};
    assign s1_valid      = &s1_pair_vld;

    for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_s1
        ktop_lane_add2_stage #(
            .C_DATA_WIDTH (C_DATA_WIDTH),
            .C_LANE_WIDTH (C_LANE_WIDTH)
        ) u_add (
            .aclk      (aclk),
            .areset    (areset),
            .en        (s1_en),
            .in_valid  (fire),
            .a         (din[2*g]),
            .b         (din[2*g+1]),
            .out_valid (s1_pair_vld[g]),
            .sum       (psum[g])
        );
    end

    ktop_lane_add2_stage #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_LANE_WIDTH (C_LANE_WIDTH)
    ) u_s2 (
        .aclk      (aclk),
        .areset    (areset),
        .en        (s2_en),
        .in_valid  (s1_valid),
        .a         (psum[0]),
        .b         (psum[1]),
        .out_valid (m_axis_tvalid),
        .sum       (m_axis_tdata)
    );

    // Beats leave in acceptance order, so in_rem==1 at fire marks the same
    // beat that will see out_rem==1 at the output.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s1_last      <= 1'b0;
            m_axis_tlast <= 1'b0;
        end else begin
            if (fire) s1_last <= (in_rem == ONE);
            if (s2_en && s1_valid) m_axis_tlast <= s1_last;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            in_rem    <= '0;
            out_rem   <= '0;
            ctrl_done <= 1'b0;
            ctrl_err  <= 1'b0;
        end else begin
            ctrl_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl_start) begin
                        in_rem   <= beats;
                        out_rem  <= beats;
                        ctrl_err <= 1'b0;
                        if (beats == '0) begin
                            state     <= DONE;
                            ctrl_done <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (fire) begin
                        in_rem <= in_rem - ONE;
                        if (s_axis_tlast != {LP_NUM_INPUTS{in_rem == ONE}}) ctrl_err <= 1'b1;
                    end
                    if (out_hs) begin
                        out_rem <= out_rem - ONE;
                        if (out_rem == ONE) begin
                            state     <= DONE;
                            ctrl_done <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ktop_stream_join4.sv
// Self-checking bench for ktop_stream_join4: table vectors, corner sequences
// and randomized transfers against a four-operand lane-sum reference.
module tb_ktop_stream_join4;

    localparam int DW  = 512;
    localparam int NL  = DW / 32;
    localparam int MAXB = 128;

    logic            clk = 1'b0;
    logic            areset;
    logic            ctrl_start;
    logic [31:0]     ctrl_xfer;
    logic            ctrl_done, ctrl_err;
    logic [3:0]      s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [4*DW-1:0] s_axis_tdata;
    logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DW-1:0]   m_axis_tdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] src [4][MAXB];
    logic [DW-1:0] out_q[$];

    typedef struct {
        int          size;
        logic [31:0] a, b, c, d;
        logic [31:0] exp_lane;
        int          exp_beats;
    } vec_t;

    vec_t vt[7];

    always #5 clk = ~clk;

    ktop_stream_join4 dut (
        .aclk                    (clk),
        .areset                  (areset),
        .ctrl_start              (ctrl_start),
        .ctrl_xfer_size_in_bytes (ctrl_xfer),
        .ctrl_done               (ctrl_done),
        .ctrl_err                (ctrl_err),
        .s_axis_tvalid           (s_axis_tvalid),
        .s_axis_tready           (s_axis_tready),
        .s_axis_tdata            (s_axis_tdata),
        .s_axis_tlast            (s_axis_tlast),
        .m_axis_tvalid           (m_axis_tvalid),
        .m_axis_tready           (m_axis_tready),
        .m_axis_tdata            (m_axis_tdata),
        .m_axis_tlast            (m_axis_tlast)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: each output lane is the 32-bit wrapped sum of four operands.
    function automatic logic [DW-1:0] model_sum(input int b);
        logic [DW-1:0] r;
        r = '0;
        for (int l = 0; l < NL; l++)
            r[l*32 +: 32] = src[0][b][l*32 +: 32] + src[1][b][l*32 +: 32]
                          + src[2][b][l*32 +: 32] + src[3][b][l*32 +: 32];
        return r;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < MAXB; b++)
                for (int l = 0; l < NL; l++)
                    src[i][b][l*32 +: 32] = $urandom;
    endtask

    // Entered at (or just after) a negedge; leaves one cycle after ctrl_done.
    task automatic run_xfer(input int size, input int skew2, input bit rnd, input int bad_beat);
        int nb, sent, got, cyc, last_hs, first_fire, first_out;
        bit done_seen, stalled, exp_err;
        logic [DW-1:0] held_d;
        logic          held_l;
        nb = (size + 63) / 64;
        exp_err = (bad_beat >= 0) && (bad_beat < nb);
        sent = 0; got = 0; cyc = 0; last_hs = -1; first_fire = -1; first_out = -1;
        done_seen = 0; stalled = 0; held_d = '0; held_l = 1'b0;
        out_q.delete();
        s_axis_tvalid = '0;
        ctrl_xfer = size;
        ctrl_start = 1'b1;
        @(negedge clk);
        ctrl_start = 1'b0;
        while (cyc < 2000 && !done_seen) begin
            for (int i = 0; i < 4; i++) begin
                s_axis_tvalid[i] = (i != 2 || cyc >= skew2) && (!rnd || $urandom_range(0, 4) != 0);
                s_axis_tdata[i*DW +: DW] = src[i][(sent < MAXB) ? sent : MAXB-1];
                s_axis_tlast[i] = (sent == nb - 1) || (i == 3 && sent == bad_beat);
            end
            m_axis_tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (cyc == 0) chk("err_clear_on_start", ctrl_err, 0);
            chk("tready_uniform", (s_axis_tready == 4'h0) || (s_axis_tready == 4'hF), 1);
            if (s_axis_tready[0]) begin
                chk("join_legal", (&s_axis_tvalid) && (sent < nb), 1);
                if (first_fire < 0) first_fire = cyc;
                sent++;
            end
            if (m_axis_tvalid) begin
                chk("no_extra_out", got < nb, 1);
                if (stalled) begin
                    chk("stall_data", m_axis_tdata, held_d);
                    chk("stall_last", m_axis_tlast, held_l);
                end
                if (m_axis_tready) begin
                    chk("out_data", m_axis_tdata, model_sum(got));
                    chk("out_last", m_axis_tlast, got == nb - 1);
                    if (first_out < 0) first_out = cyc;
                    out_q.push_back(m_axis_tdata);
                    got++;
                    last_hs = cyc;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held_d = m_axis_tdata;
                    held_l = m_axis_tlast;
                end
            end
            if (ctrl_done) begin
                done_seen = 1;
                chk("done_timing", cyc, (nb == 0) ? 0 : last_hs + 1);
                chk("err_at_done", ctrl_err, exp_err);
            end
            cyc++;
            @(negedge clk);
        end
        chk("done_seen", done_seen, 1);
        chk("beats_out", got, nb);
        chk("beats_in", sent, nb);
        if (!rnd && skew2 == 0 && nb > 0) chk("latency", first_out, first_fire + 2);
        s_axis_tvalid = '0;
        s_axis_tlast = '0;
        #1;
        chk("done_pulse_one_cycle", ctrl_done, 0);
    endtask

    initial begin
        logic [DW-1:0] rep;
        int n;
        areset = 1'b1;
        ctrl_start = 1'b0;
        ctrl_xfer = '0;
        s_axis_tvalid = '0;
        s_axis_tlast = '0;
        s_axis_tdata = '0;
        m_axis_tready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_mvalid", m_axis_tvalid, 0);
        chk("rst_mdata", m_axis_tdata, 0);
        chk("rst_mlast", m_axis_tlast, 0);
        chk("rst_done", ctrl_done, 0);
        chk("rst_err", ctrl_err, 0);
        areset = 1'b0;
        @(negedge clk);

        vt[0] = '{256,  32'd1,          32'd2,          32'd3,          32'd4,          32'd10,   4};
        vt[1] = '{64,   32'hFFFFFFFF,   32'd1,          32'd0,          32'd0,          32'd0,    1};
        vt[2] = '{128,  32'h80000000,   32'h80000000,   32'h80000000,   32'h80000000,   32'd0,    2};
        vt[3] = '{65,   32'd5,          32'd6,          32'd7,          32'd8,          32'd26,   2};
        vt[4] = '{0,    32'd9,          32'd9,          32'd9,          32'd9,          32'd0,    0};
        vt[5] = '{1,    32'h7FFFFFFF,   32'h7FFFFFFF,   32'd2,          32'd0,          32'd0,    1};
        vt[6] = '{192,  32'd100,        32'd200,        32'd300,        32'd400,        32'd1000, 3};

        for (int v = 0; v < 7; v++) begin
            fill_random();
            for (int b = 0; b < MAXB; b++) begin
                src[0][b] = {NL{vt[v].a}};
                src[1][b] = {NL{vt[v].b}};
                src[2][b] = {NL{vt[v].c}};
                src[3][b] = {NL{vt[v].d}};
            end
            run_xfer(vt[v].size, 0, 0, -1);
            chk("table_beats", out_q.size(), vt[v].exp_beats);
            rep = {NL{vt[v].exp_lane}};
            foreach (out_q[k]) chk("table_lanes", out_q[k], rep);
        end

        // Input 2 late, random valid gaps and output backpressure over 64 beats.
        fill_random();
        run_xfer(64 * 64 - 5, 5, 1, -1);

        // tlast on input 3 at beat 2 sets the sticky error; the next start clears it.
        fill_random();
        run_xfer(256, 0, 0, 1);
        fill_random();
        run_xfer(256, 0, 0, -1);

        for (int r = 0; r < 6; r++) begin
            fill_random();
            run_xfer($urandom_range(0, 1000), $urandom_range(0, 3), 1, -1);
        end

        // Reset after three of eight beats are accepted.
        fill_random();
        ctrl_xfer = 512;
        ctrl_start = 1'b1;
        @(negedge clk);
        ctrl_start = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && n < 3; k++) begin
            s_axis_tvalid = 4'hF;
            for (int i = 0; i < 4; i++) s_axis_tdata[i*DW +: DW] = src[i][n];
            s_axis_tlast = '0;
            m_axis_tready = 1'b1;
            #1;
            if (s_axis_tready[0]) n++;
            @(negedge clk);
        end
        #1;
        chk("pre_reset_busy", m_axis_tvalid, 1);
        #1;
        areset = 1'b1;
        #1;
        chk("midrst_tready", s_axis_tready, 0);
        chk("midrst_mvalid", m_axis_tvalid, 0);
        chk("midrst_mdata", m_axis_tdata, 0);
        chk("midrst_mlast", m_axis_tlast, 0);
        chk("midrst_done", ctrl_done, 0);
        chk("midrst_err", ctrl_err, 0);
        s_axis_tvalid = '0;
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        #1;
        chk("postrst_no_done", ctrl_done, 0);
        chk("postrst_no_valid", m_axis_tvalid, 0);
        fill_random();
        run_xfer(128, 0, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
